lemmings_world: RTL and testbench

- Terrain/environment model for the lemming controller FSM: the producer of its sensor inputs.
- Takes the controller's Moore outputs (walk direction, digging) and advances one lemming through a 1-D world of columns.
- Returns `ground`, `bump_left` and `bump_right`, plus position, depth and fall telemetry.
- Sits opposite the controller in the closed-loop bench harness.

---
 rtl/lemmings_world.sv | 151 +++++++++++++++
 tb/tb_lemmings_world.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lemmings_world.sv
// -----------------------------------------------------------------------------
// lemmings_world
//
// Terrain model that sits opposite the lemming controller in a closed-loop
// harness. It consumes the controller's Moore outputs (walk direction,
// digging) and moves one lemming through a 1-D row of columns. Each column
// has a floor height floor_y (0 = surface, DEPTH = void) that digging can
// lower one layer at a time.
//
// This block has no valid/ready handshakes. Every input is sampled on every
// rising clock edge. Every output is a pure function of the registered state,
// plus the current walk inputs for the bumps. Because the controller is
// Moore, this cannot form a combinational loop.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high; restores terrain and lemming
//   walk_left   in   controller is walking left
//   walk_right  in   controller is walking right
//   digging     in   controller is digging
//   ground      out  lemming stands on a floor (y == floor_y[pos])
//   bump_left   out  a left move is blocked this cycle
//   bump_right  out  a right move is blocked this cycle
//   pos         out  current column
//   depth       out  current depth y below the surface
//   fall_cnt    out  consecutive falling cycles, saturating at 31
//   exited      out  lemming dropped into the void (sticky until reset)
// -----------------------------------------------------------------------------
module lemmings_world #(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 7,
  parameter int               START_POS  = 2,
  parameter logic [WIDTH-1:0] SOLID_MASK = 16'hFFF7,
  parameter logic [WIDTH-1:0] WALL_MASK  = 16'h8001,
  parameter int               DIG_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         walk_left,
  input  logic                         walk_right,
  input  logic                         digging,
  output logic                         ground,
  output logic                         bump_left,
  output logic                         bump_right,
  output logic [$clog2(WIDTH)-1:0]     pos,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [4:0]                   fall_cnt,
  output logic                         exited
);

  localparam int PW = $clog2(WIDTH);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

  localparam logic [DW-1:0] VOID_Y   = DW'(DEPTH);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIG_CYCLES - 1);

  // Terrain and lemming state
  logic [DW-1:0] r_floor_y [WIDTH];
  logic [PW-1:0] r_pos;
  logic [DW-1:0] r_y;
  logic [CW-1:0] r_dig_cnt;
  logic [4:0]    r_fall_cnt;
  logic          r_exited;

  // Derived combinational signals
  logic          w_at_left;
  logic          w_at_right;
  logic [PW-1:0] w_left_idx;
  logic [PW-1:0] w_right_idx;
  logic          w_blocked_left;
  logic          w_blocked_right;
  logic          w_ground;
  logic          w_walk_one;
  logic [DW-1:0] w_y_next;

  always_comb begin
    w_at_left  = (r_pos == '0);
    w_at_right = (r_pos == PW'(WIDTH - 1));
    // At an edge, clamp the neighbour index to the current column. The
    // edge flag already forces "blocked", so the clamped lookup is don't-care.
    w_left_idx  = w_at_left  ? r_pos : r_pos - 1'b1;
    w_right_idx = w_at_right ? r_pos : r_pos + 1'b1;

    // A neighbour is blocked if it is a wall, or if its floor is higher
    // than the lemming's current level (the lemming cannot climb).
    w_blocked_left  = w_at_left  || WALL_MASK[w_left_idx]  ||
                      (r_floor_y[w_left_idx]  < r_y);
    w_blocked_right = w_at_right || WALL_MASK[w_right_idx] ||
                      (r_floor_y[w_right_idx] < r_y);

    w_ground   = !r_exited && (r_y == r_floor_y[r_pos]);
    w_walk_one = walk_left ^ walk_right;
    w_y_next   = r_y + 1'b1;
  end

  assign ground     = w_ground;
  assign bump_left  = w_ground && walk_left  && !walk_right && w_blocked_left;
  assign bump_right = w_ground && walk_right && !walk_left  && w_blocked_right;
  assign pos        = r_pos;
  assign depth      = r_y;
  assign fall_cnt   = r_fall_cnt;
  assign exited     = r_exited;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < WIDTH; c++) begin
        r_floor_y[c] <= SOLID_MASK[c] ? '0 : VOID_Y;
      end
      r_pos      <= PW'(START_POS);
      r_y        <= '0;
      r_dig_cnt  <= '0;
      r_fall_cnt <= '0;
      r_exited   <= 1'b0;
    end else if (r_exited) begin
      // Gone into the void: the world freezes until the next reset.
    end else if (!w_ground) begin
      // Falling: one layer per edge. Controller inputs are ignored.
      r_y        <= w_y_next;
      r_fall_cnt <= (r_fall_cnt == 5'd31) ? 5'd31 : r_fall_cnt + 5'd1;
      r_dig_cnt  <= '0;
      if (w_y_next == VOID_Y) begin
        r_exited <= 1'b1;
      end
    end else if (digging) begin
      r_fall_cnt <= '0;
      if (r_dig_cnt == DIG_LAST) begin
        // The layer is gone. ground drops next cycle and the fall begins
        // on the edge after that.
        r_floor_y[r_pos] <= r_floor_y[r_pos] + 1'b1;
        r_dig_cnt        <= '0;
      end else begin
        r_dig_cnt <= r_dig_cnt + 1'b1;
      end
    end else if (w_walk_one) begin
      r_fall_cnt <= '0;
      r_dig_cnt  <= '0;
      if (walk_left && !w_blocked_left) begin
        r_pos <= r_pos - 1'b1;
      end else if (walk_right && !w_blocked_right) begin
        r_pos <= r_pos + 1'b1;
      end
    end else begin
      // Idle, or both walk inputs asserted: hold position. Any partial dig
      // progress is discarded.
      r_fall_cnt <= '0;
      r_dig_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_lemmings_world.sv
// -----------------------------------------------------------------------------
// tb_lemmings_world
//
// Directed bench for lemmings_world with default parameters. The expected
// values are computed by hand from the terrain rules:
//   column 0 and column 15 are walls,
//   column 3 is a pit (floor = 7 = void),
//   all other columns have floor 0,
//   the lemming starts at column 2.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// checked 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_lemmings_world;

  logic       clk = 1'b0;
  logic       reset;
  logic       walk_left;
  logic       walk_right;
  logic       digging;
  logic       ground;
  logic       bump_left;
  logic       bump_right;
  logic [3:0] pos;
  logic [2:0] depth;
  logic [4:0] fall_cnt;
  logic       exited;

  int n_cmp = 0;
  int n_err = 0;

  lemmings_world dut (
    .clk        (clk),
    .reset      (reset),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .digging    (digging),
    .ground     (ground),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .pos        (pos),
    .depth      (depth),
    .fall_cnt   (fall_cnt),
    .exited     (exited)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wl, input logic wr, input logic dg);
    walk_left  = wl;
    walk_right = wr;
    digging    = dg;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_home(input string tag);
    check_eq({tag, " pos"},      pos,        2);
    check_eq({tag, " depth"},    depth,      0);
    check_eq({tag, " ground"},   ground,     1);
    check_eq({tag, " fall_cnt"}, fall_cnt,   0);
    check_eq({tag, " exited"},   exited,     0);
    check_eq({tag, " bump_l"},   bump_left,  0);
    check_eq({tag, " bump_r"},   bump_right, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check_home("reset");

    // Wall bump: walk left from column 2 toward the wall at column 0.
    drive(1'b1, 1'b0, 1'b0);
    check_eq("wall pre bump_l", bump_left, 0);
    tick();
    check_eq("wall c1 pos",    pos,        1);
    check_eq("wall c1 bump_l", bump_left,  1);
    check_eq("wall c1 bump_r", bump_right, 0);
    tick();
    check_eq("wall c2 pos",    pos,        1);
    check_eq("wall c2 bump_l", bump_left,  1);
    check_eq("wall c2 bump_r", bump_right, 0);

    // Both walk inputs at column 1 (left is blocked): hold, with no bump.
    drive(1'b1, 1'b1, 1'b0);
    check_eq("both bump_l", bump_left,  0);
    check_eq("both bump_r", bump_right, 0);
    tick();
    check_eq("both pos", pos, 1);

    // Dig at column 2: the layer is removed on the fourth edge.
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("dig ground", ground, 1);
      check_eq("dig depth",  depth,  0);
    end
    tick();
    check_eq("dig4 ground", ground,   0);
    check_eq("dig4 depth",  depth,    0);
    check_eq("dig4 fall",   fall_cnt, 0);
    tick();
    check_eq("dig5 depth",  depth,    1);
    check_eq("dig5 ground", ground,   1);
    check_eq("dig5 fall",   fall_cnt, 1);

    // Dug-in bump: column 1 still has floor 0, above the lemming at depth 1.
    drive(1'b1, 1'b0, 1'b0);
    check_eq("dugin bump_l", bump_left, 1);
    tick();
    check_eq("dugin pos",    pos,       2);
    check_eq("dugin depth",  depth,     1);
    check_eq("dugin fall",   fall_cnt,  0);

    // After reset the dug column is back at floor 0, so ground is restored.
    do_reset();
    check_home("reset after dig");

    // Interrupted dig: 2 edges of digging, 1 idle edge, then 4 fresh edges.
    drive(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("idig ground", ground, 1);
    end
    tick();
    check_eq("idig4 ground", ground, 0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("idig5 depth", depth, 1);

    // Pit fall: walk right from column 2 into the pit at column 3.
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    check_eq("pit pre bump_r", bump_right, 0);
    tick();
    check_eq("pit e1 pos",    pos,    3);
    check_eq("pit e1 ground", ground, 0);
    check_eq("pit e1 depth",  depth,  0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("pit depth",  depth,    k);
      check_eq("pit fall",   fall_cnt, k);
      check_eq("pit exited", exited,   (k == 7) ? 1 : 0);
      check_eq("pit ground", ground,   0);
    end
    // After exiting, every output stays frozen whatever the inputs do.
    for (int i = 0; i < 3; i++) begin
      drive(i[0], !i[0], i[1]);
      tick();
      check_eq("frozen pos",    pos,        3);
      check_eq("frozen depth",  depth,      7);
      check_eq("frozen fall",   fall_cnt,   7);
      check_eq("frozen exited", exited,     1);
      check_eq("frozen ground", ground,     0);
      check_eq("frozen bump_l", bump_left,  0);
      check_eq("frozen bump_r", bump_right, 0);
    end

    // Reset in the middle of a fall.
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check_eq("midfall depth", depth,    3);
    check_eq("midfall fall",  fall_cnt, 3);
    do_reset();
    check_home("midfall reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
